motor_step_driver: RTL and testbench



---
 rtl/motor_pkg.sv | 36 +++
 rtl/motor_step_driver_pwm_gen.sv | 31 +++
 rtl/motor_step_driver.sv | 151 +++++++++++++++
 tb/tb_motor_step_driver.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared types and instruction field layout for the wheel motor step driver.
package motor_pkg;

    typedef enum logic [1:0] {
        DIR_FWD   = 2'b00,
        DIR_REV   = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BRAKE = 2'd2
    } state_e;

    localparam int unsigned INSTR_W = 4;
    localparam int unsigned DIR_LSB = 0;
    localparam int unsigned DIR_MSB = 1;
    localparam int unsigned TRQ_LSB = 2;
    localparam int unsigned TRQ_MSB = 3;

    // Wheel direction bits {left_fwd, right_fwd}; spins turn the wheels against each other.
    function automatic logic [1:0] wheel_fwd(input dir_e dir);
        logic [1:0] fwd;
        case (dir)
            DIR_FWD:   fwd = 2'b11;
            DIR_REV:   fwd = 2'b00;
            DIR_LEFT:  fwd = 2'b01;
            DIR_RIGHT: fwd = 2'b10;
            default:   fwd = 2'b11;
        endcase
        return fwd;
    endfunction

endpackage

// File: rtl/motor_step_driver_pwm_gen.sv
// Free-running PWM generator; the counter is held at zero whenever en is low.
module pwm_gen #(
    parameter int unsigned PWM_PERIOD = 1000,
    parameter int unsigned CNT_W      = $clog2(PWM_PERIOD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] duty,
    output logic             pwm
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             pwm_q;

    // en/duty describe the coming cycle, so the registered output lines up with the count.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= (cnt_q < duty);
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/motor_step_driver.sv
// Executes one queued motion instruction: timed RUN with PWM drive, BRAKE dead time, then done.
module motor_step_driver
    import motor_pkg::*;
#(
    parameter int unsigned PWM_PERIOD   = 1000,
    parameter int unsigned STEP_CYCLES  = 50000000,
    parameter int unsigned BRAKE_CYCLES = 5000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    input  logic               abort,
    output logic               instr_ready,
    output logic               busy,
    output logic               done,
    output logic               left_pwm,
    output logic               right_pwm,
    output logic               left_fwd,
    output logic               right_fwd,
    output logic [1:0]         active_dir
);

    localparam int unsigned DWELL_MAX = (STEP_CYCLES > BRAKE_CYCLES) ? STEP_CYCLES : BRAKE_CYCLES;
    localparam int unsigned DWELL_W   = $clog2(DWELL_MAX + 1);
    localparam int unsigned DUTY_W    = $clog2(PWM_PERIOD + 1);
    localparam int unsigned QUARTER   = PWM_PERIOD / 4;

    localparam logic [DWELL_W-1:0] STEP_LAST  = DWELL_W'(STEP_CYCLES - 1);
    localparam logic [DWELL_W-1:0] BRAKE_LAST = DWELL_W'(BRAKE_CYCLES - 1);

    state_e              state_q;
    dir_e                dir_q;
    logic [DWELL_W-1:0]  dwell_q;
    logic [DUTY_W-1:0]   duty_q;
    logic [DUTY_W-1:0]   duty_d;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;
    logic                lfwd_q;
    logic                rfwd_q;

    dir_e                dir_in;
    logic [1:0]          trq_in;
    logic                accept;
    logic                run_en;

    assign dir_in = dir_e'(instr[DIR_MSB:DIR_LSB]);
    assign trq_in = instr[TRQ_MSB:TRQ_LSB];
    assign accept = ready_q & instr_valid;

    // PWM enable and duty for the coming cycle: high while the next cycle is a RUN cycle.
    always_comb begin
        duty_d = duty_q;
        run_en = 1'b0;
        if (accept) begin
            duty_d = DUTY_W'((32'(trq_in) + 32'd1) * QUARTER);
            run_en = 1'b1;
        end else if (state_q == RUN) begin
            run_en = !abort && (dwell_q != STEP_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_FWD;
            dwell_q <= '0;
            duty_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lfwd_q  <= 1'b1;
            rfwd_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            duty_q <= duty_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q          <= RUN;
                        dir_q            <= dir_in;
                        dwell_q          <= '0;
                        ready_q          <= 1'b0;
                        busy_q           <= 1'b1;
                        {lfwd_q, rfwd_q} <= wheel_fwd(dir_in);
                    end
                end
                RUN: begin
                    // An abort on the final RUN cycle lands in the same place as expiry.
                    if (abort || (dwell_q == STEP_LAST)) begin
                        state_q <= BRAKE;
                        dwell_q <= '0;
                    end else begin
                        dwell_q <= dwell_q + DWELL_W'(1);
                    end
                end
                BRAKE: begin
                    if (dwell_q == BRAKE_LAST) begin
                        state_q <= IDLE;
                        dir_q   <= DIR_FWD;
                        dwell_q <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        lfwd_q  <= 1'b1;
                        rfwd_q  <= 1'b1;
                    end else begin
                        dwell_q <= dwell_q + DWELL_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Both wheels share one duty; two generators keep the per-wheel outputs independent.
    pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .CNT_W      (DUTY_W)
    ) u_pwm_left (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .duty (duty_d),
        .pwm  (left_pwm)
    );

    pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .CNT_W      (DUTY_W)
    ) u_pwm_right (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .duty (duty_d),
        .pwm  (right_pwm)
    );

    assign instr_ready = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign left_fwd    = lfwd_q;
    assign right_fwd   = rfwd_q;
    assign active_dir  = dir_q;

endmodule

// File: tb/tb_motor_step_driver.sv
// Scoreboard bench: each accepted instruction pushes its per-cycle expected outputs; a monitor pops and compares.
module tb_motor_step_driver;

    localparam int PWM   = 8;
    localparam int STEP  = 32;
    localparam int BRAKE = 4;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       done;
        logic       lpwm;
        logic       rpwm;
        logic       lfwd;
        logic       rfwd;
        logic [1:0] dir;
    } obs_t;

    localparam obs_t IDLE_OBS = '{ready: 1'b1, busy: 1'b0, done: 1'b0, lpwm: 1'b0, rpwm: 1'b0,
                                  lfwd: 1'b1, rfwd: 1'b1, dir: 2'b00};

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic [3:0] instr;
    logic       abort;
    logic       instr_ready;
    logic       busy;
    logic       done;
    logic       left_pwm;
    logic       right_pwm;
    logic       left_fwd;
    logic       right_fwd;
    logic [1:0] active_dir;

    int   checks;
    int   errors;
    bit   mon_en;
    obs_t exp_q[$];
    obs_t got_v;
    obs_t exp_v;

    motor_step_driver #(
        .PWM_PERIOD   (PWM),
        .STEP_CYCLES  (STEP),
        .BRAKE_CYCLES (BRAKE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .abort       (abort),
        .instr_ready (instr_ready),
        .busy        (busy),
        .done        (done),
        .left_pwm    (left_pwm),
        .right_pwm   (right_pwm),
        .left_fwd    (left_fwd),
        .right_fwd   (right_fwd),
        .active_dir  (active_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: whole-transaction expected trace from the instruction and its RUN length.
    task automatic push_tx(input logic [3:0] ins, input int run_len);
        logic [1:0] d;
        logic [1:0] tq;
        int         duty;
        logic       lf;
        logic       rf;
        logic       p;
        obs_t       o;
        d    = ins[1:0];
        tq   = ins[3:2];
        duty = (int'(tq) + 1) * PWM / 4;
        lf   = (d == 2'b00) || (d == 2'b11);
        rf   = (d == 2'b00) || (d == 2'b10);
        for (int i = 1; i <= run_len; i++) begin
            p = (((i - 1) % PWM) < duty);
            o = '{ready: 1'b0, busy: 1'b1, done: 1'b0, lpwm: p, rpwm: p, lfwd: lf, rfwd: rf, dir: d};
            exp_q.push_back(o);
        end
        for (int b = 0; b < BRAKE; b++) begin
            o = '{ready: 1'b0, busy: 1'b1, done: 1'b0, lpwm: 1'b0, rpwm: 1'b0, lfwd: lf, rfwd: rf, dir: d};
            exp_q.push_back(o);
        end
        o = '{ready: 1'b1, busy: 1'b0, done: 1'b1, lpwm: 1'b0, rpwm: 1'b0, lfwd: 1'b1, rfwd: 1'b1, dir: 2'b00};
        exp_q.push_back(o);
    endtask

    // Monitor: every cycle the DUT presents one output vector; compare it with the scoreboard head.
    always @(negedge clk) begin
        if (mon_en) begin
            got_v = '{ready: instr_ready, busy: busy, done: done, lpwm: left_pwm, rpwm: right_pwm,
                      lfwd: left_fwd, rfwd: right_fwd, dir: active_dir};
            if (exp_q.size() > 0) exp_v = exp_q.pop_front();
            else                  exp_v = IDLE_OBS;
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL outputs @%0t [rdy busy done lpwm rpwm lfwd rfwd dir] got=%b expected=%b",
                         $time, got_v, exp_v);
            end
        end
    end

    task automatic idle_gap(input int n);
        instr_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            instr = 4'($urandom);
            abort = 1'($urandom);
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask

    // Issue one instruction; optional abort on RUN cycle abort_at, optional reset on cycle rst_at.
    task automatic do_tx(input logic [3:0] ins, input int abort_at, input int rst_at, input bit hold);
        int run_len;
        bit ok;
        run_len     = (abort_at >= 1 && abort_at < STEP) ? abort_at : STEP;
        instr_valid = 1'b1;
        instr       = ins;
        abort       = 1'b0;
        ok          = 1'b0;
        for (int w = 0; w < 100 && !ok; w++) begin
            @(negedge clk); #1;
            if (instr_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout @%0t ready=%b required=1", $time, instr_ready);
            instr_valid = 1'b0;
            return;
        end
        push_tx(ins, run_len);
        @(posedge clk); #1;
        instr_valid = hold;
        for (int j = 1; j <= run_len + BRAKE; j++) begin
            if (j == rst_at) begin
                rst   = 1'b1;
                abort = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                exp_q.delete();
                instr_valid = 1'b0;
                return;
            end
            instr = 4'($urandom);
            abort = (j == abort_at) || (j > run_len && $urandom_range(0, 1) == 1);
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        mon_en      = 1'b0;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 4'h0;
        abort       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        idle_gap(3);

        do_tx(4'b0100, 0, 0, 1'b0);
        do_tx(4'b1110, 0, 0, 1'b0);
        do_tx(4'b0011, 0, 0, 1'b0);
        idle_gap(2);
        do_tx(4'b0000, 10, 0, 1'b0);
        do_tx(4'b0101, STEP, 0, 1'b0);
        do_tx(4'b1011, 1, 0, 1'b0);
        do_tx(4'b1001, 0, 0, 1'b1);
        do_tx(4'b0110, 0, 0, 1'b0);
        idle_gap(1);
        do_tx(4'b1100, 0, 15, 1'b0);
        do_tx(4'b0111, 0, STEP + 2, 1'b0);
        do_tx(4'b0001, 0, 0, 1'b0);

        for (int t = 0; t < 16; t++) begin
            logic [3:0] ins;
            int         ab;
            int         rs;
            bit         hold;
            ins  = 4'($urandom);
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, STEP + BRAKE)) : 0;
            rs   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, STEP + BRAKE)) : 0;
            hold = (t < 15) ? 1'($urandom) : 1'b0;
            do_tx(ins, ab, rs, hold);
            if (!hold) idle_gap(int'($urandom_range(0, 3)));
        end

        for (int w = 0; w < 200 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
        idle_gap(3);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
